// File: rtl/rud_ripple_counter.sv
// -----------------------------------------------------------------------------
// rud_ripple_counter
//
// Asynchronous ripple up/down counter. Only stage 0 is clocked by clk; every
// higher stage is clocked by the output of the stage below it. The count
// direction comes from a mode register captured on falling clk edges, so a
// mode change settles well before the next rising edge starts a ripple.
//
// Each stage j>=1 is a pair of toggle flops (a, b) whose XOR is the stage
// output. 'a' advances on the falling edge of the lower stage (count up) and
// 'b' on its rising edge (count down). The stage clocks are the lower stage
// outputs themselves, never a mux, so flipping the mode cannot create a
// spurious edge and the count is preserved across a mode change.
//
// Ports:
//   clk    in   1      system clock; stage 0 toggles on the rising edge
//   reset  in   1      asynchronous active-low reset, clears all state
//   m      in   1      mode select: 0 = count up, 1 = count down
//   out    out  WIDTH  current count (sample on falling clk edges)
//   tc     out  1      terminal-count flag, only when RUD_TC_EN is defined
//
// Build option:
//   RUD_TC_EN  adds the combinational terminal-count output tc.
// -----------------------------------------------------------------------------
module rud_ripple_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m,
`ifdef RUD_TC_EN
  output logic [WIDTH-1:0] out,
  output logic             tc
`else
  output logic [WIDTH-1:0] out
`endif
);

  // Settled stage outputs; each bit also serves as the clock of the next stage.
  wire [WIDTH-1:0] stage_s;

  logic m_d;
  logic m_q;
  logic s0_d;
  logic s0_q;

  // Next value of the mode register is simply the raw mode input.
  always_comb begin
    m_d = m;
  end

  // Mode register: captured on the falling clk edge, away from the ripple.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_q <= 1'b0;
    end else begin
      m_q <= m_d;
    end
  end

  // Stage 0 toggles on every rising clk edge in both directions.
  always_comb begin
    s0_d = ~s0_q;
  end

  // Stage 0 flop, clocked by the system clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
    end
  end

  assign stage_s[0] = s0_q;

  for (genvar j = 1; j < WIDTH; j++) begin : g_stage
    logic a_d;
    logic a_q;
    logic b_d;
    logic b_q;

    // Up-count flop toggles only when the mode register says up.
    always_comb begin
      if (m_q == 1'b0) begin
        a_d = ~a_q;
      end else begin
        a_d = a_q;
      end
    end

    // Down-count flop toggles only when the mode register says down.
    always_comb begin
      if (m_q == 1'b1) begin
        b_d = ~b_q;
      end else begin
        b_d = b_q;
      end
    end

    // Up-count flop: a falling lower stage is a carry when counting up.
    always_ff @(negedge stage_s[j-1] or negedge reset) begin
      if (!reset) begin
        a_q <= 1'b0;
      end else begin
        a_q <= a_d;
      end
    end

    // Down-count flop: a rising lower stage is a borrow when counting down.
    always_ff @(posedge stage_s[j-1] or negedge reset) begin
      if (!reset) begin
        b_q <= 1'b0;
      end else begin
        b_q <= b_d;
      end
    end

    // Either flop toggling flips the stage, so XOR gives the stage value.
    assign stage_s[j] = a_q ^ b_q;
  end

  assign out = stage_s;

`ifdef RUD_TC_EN
  // Terminal count: all ones when counting up, all zeros when counting down.
  always_comb begin
    if (!reset) begin
      tc = 1'b0;
    end else if (m_q == 1'b0) begin
      tc = &stage_s;
    end else begin
      tc = ~|stage_s;
    end
  end
`endif

endmodule

// File: tb/tb_rud_ripple_counter.sv
// -----------------------------------------------------------------------------
// Testbench for rud_ripple_counter (WIDTH = 3). Expected counts come from a
// small reference model and are queued when a rising edge is launched, then
// popped and compared against the DUT at the following falling edge.
// -----------------------------------------------------------------------------
module tb_rud_ripple_counter;

  localparam int W = 3;

  logic         clk;
  logic         reset;
  logic         m;
  logic [W-1:0] out;
`ifdef RUD_TC_EN
  logic         tc;
`endif

  int checks;
  int failures;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] model_cnt;
  logic         model_mode;

  rud_ripple_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .m     (m),
`ifdef RUD_TC_EN
    .out   (out),
    .tc    (tc)
`else
    .out   (out)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_tc(input string tag, input logic exp_tc);
`ifdef RUD_TC_EN
    checks++;
    assert (tc === exp_tc) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, tc, exp_tc);
    end
`else
    if (exp_tc === 1'bx) $display("unreachable");
`endif
  endtask

  function automatic logic model_tc(input logic mode, input logic [W-1:0] cnt);
    if (mode == 1'b0) return (cnt == 3'b111);
    else return (cnt == 3'b000);
  endfunction

  // One counting step: queue the expected count, launch a rising edge, set the
  // next mode before the falling edge (where it is captured), then compare.
  task automatic step(input string tag, input logic new_m);
    logic [W-1:0] exp_v;
    if (model_mode == 1'b0) model_cnt = model_cnt + 3'd1;
    else model_cnt = model_cnt - 3'd1;
    sb_q.push_back(model_cnt);
    @(posedge clk);
    #2;
    m = new_m;
    @(negedge clk);
    #1;
    model_mode = new_m;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      exp_v = sb_q.pop_front();
      check(tag, out, exp_v);
      check_tc({tag, "_tc"}, model_tc(model_mode, model_cnt));
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    m          = 1'b0;
    model_cnt  = 3'b000;
    model_mode = 1'b0;

    // Reset pulse of 10 ns with clk low at the start; a rising edge lands inside.
    #2;
    reset = 1'b0;
    #1;
    check("reset_async", out, 3'b000);
    check_tc("reset_tc", 1'b0);
    #8;
    check("reset_hold_over_edge", out, 3'b000);
    check_tc("reset_hold_tc", 1'b0);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("after_release", out, 3'b000);

    // Up count: nine rising edges, wrapping through 000.
    for (int i = 0; i < 9; i++) step($sformatf("up%0d", i), 1'b0);

    // Continue up to 101, switching to down on the edge that reaches 101.
    for (int i = 0; i < 3; i++) step($sformatf("up_more%0d", i), 1'b0);
    step("up_to_101_switch", 1'b1);
    #5;
    check("mode_switch_hold", out, 3'b101);
    step("down_after_switch", 1'b1);

    // Down through 000 and a full wrap back to 000.
    for (int i = 0; i < 4; i++) step($sformatf("down_a%0d", i), 1'b1);
    for (int i = 0; i < 7; i++) step($sformatf("down_b%0d", i), 1'b1);
    step("down_last_to_up", 1'b0);
    check("down_wrap_zero", out, 3'b000);

    // Count up to 110, then reset between clock edges.
    for (int i = 0; i < 6; i++) step($sformatf("up_c%0d", i), 1'b0);
    check("pre_reset_110", out, 3'b110);
    #3;
    reset = 1'b0;
    #1;
    check("midrun_reset", out, 3'b000);
    check_tc("midrun_reset_tc", 1'b0);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(3'b000);
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("reset_low_clk%0d", i), out, sb_q.pop_front());
      check_tc($sformatf("reset_low_tc%0d", i), 1'b0);
    end
    #3;
    reset = 1'b1;
    model_cnt  = 3'b000;
    model_mode = 1'b0;
    for (int i = 0; i < 8; i++) step($sformatf("post_reset%0d", i), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
